// File: rtl/intt_output_collector.sv
// rtl/intt_output_collector.sv - captures the final INTT router beats and streams them in natural coefficient order
// One result buffer: COLLECT fills it beat by beat, DRAIN serializes it one coefficient per cycle.
module intt_output_collector #(
  parameter int LOG_CORE_COUNT = 5,
  parameter int LOG_N          = 12,
  parameter int ADDR_W         = 9
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic                                        in_valid,
  output logic                                        in_ready,
  input  logic [(1<<LOG_CORE_COUNT)-1:0][1:0][59:0]   in_data,
  input  logic [ADDR_W-1:0]                           in_addr,
  output logic [29:0]                                 m_data,
  output logic [LOG_N-1:0]                            m_index,
  output logic                                        m_valid,
  input  logic                                        m_ready,
  output logic                                        m_last,
  output logic                                        err_addr,
  output logic                                        busy
);

  localparam int CORES     = 1 << LOG_CORE_COUNT;
  localparam int WORD_W    = 120 * CORES;
  localparam int LOG_CW    = LOG_CORE_COUNT + 2;
  localparam int LOG_BEATS = LOG_N - LOG_CW;
  localparam int BEATS     = 1 << LOG_BEATS;

  typedef enum logic {S_COLLECT, S_DRAIN} state_t;

  state_t               state, state_next;
  logic [BEATS-1:0]     bitmap;
  logic [BEATS-1:0]     bitmap_hit;
  logic [WORD_W-1:0]    mem [BEATS];
  logic [WORD_W-1:0]    in_flat;
  logic [WORD_W-1:0]    shreg;
  logic [LOG_BEATS-1:0] beat_sel;
  logic [LOG_BEATS-1:0] next_beat;
  logic                 accept, addr_ok, fill_done, xfer, beat_end, load_first;

  // Packed layout puts coefficient 4k+q at bit offset 30*(4k+q), so the beat is a plain shift chain.
  assign in_flat    = in_data;
  assign in_ready   = (state == S_COLLECT);
  assign accept     = in_valid & in_ready;
  assign addr_ok    = (in_addr < ADDR_W'(BEATS));
  assign beat_sel   = in_addr[LOG_BEATS-1:0];
  assign bitmap_hit = BEATS'(1) << beat_sel;
  assign fill_done  = accept & addr_ok & ((bitmap | bitmap_hit) == '1);
  assign xfer       = m_valid & m_ready;
  assign m_last     = m_valid & (&m_index);
  assign beat_end   = &m_index[LOG_CW-1:0];
  assign next_beat  = m_index[LOG_N-1:LOG_CW] + LOG_BEATS'(1);
  assign load_first = (state == S_DRAIN) & ~m_valid;
  assign m_data     = shreg[29:0];
  assign busy       = (state == S_DRAIN) | (|bitmap);

  always_comb begin
    state_next = state;
    case (state)
      S_COLLECT: if (fill_done) state_next = S_DRAIN;
      S_DRAIN:   if (xfer && m_last) state_next = S_COLLECT;
      default:   state_next = S_COLLECT;
    endcase
  end

  // Buffer is not reset; word 0 is read one edge after the completing write, so no bypass path is needed.
  always_ff @(posedge clk) begin
    if (accept && addr_ok) mem[beat_sel] <= in_flat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_COLLECT;
      bitmap   <= '0;
      m_valid  <= 1'b0;
      m_index  <= '0;
      shreg    <= '0;
      err_addr <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        if (!addr_ok) begin
          err_addr <= 1'b1;
        end else begin
          if (bitmap[beat_sel]) err_addr <= 1'b1;
          bitmap <= bitmap | bitmap_hit;
        end
      end
      if (load_first) begin
        shreg   <= mem[0];
        m_valid <= 1'b1;
        m_index <= '0;
      end else if (xfer) begin
        if (m_last) begin
          m_valid <= 1'b0;
          m_index <= '0;
          bitmap  <= '0;
        end else begin
          m_index <= m_index + LOG_N'(1);
          if (beat_end) shreg <= mem[next_beat];
          else          shreg <= shreg >> 30;
        end
      end
    end
  end

endmodule

// File: tb/tb_intt_output_collector.sv
// tb/tb_intt_output_collector.sv - directed self-checking bench for intt_output_collector
module tb_intt_output_collector;

  logic                   clk, rst_n, in_valid, in_ready, m_valid, m_ready, m_last, err_addr, busy;
  logic [31:0][1:0][59:0] in_data;
  logic [8:0]             in_addr;
  logic [29:0]            m_data;
  logic [11:0]            m_index;

  int checks = 0;
  int failures = 0;
  logic [29:0] exp_mem [4096];

  intt_output_collector #(.LOG_CORE_COUNT(5), .LOG_N(12), .ADDR_W(9)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_addr(in_addr), .m_data(m_data), .m_index(m_index), .m_valid(m_valid), .m_ready(m_ready),
    .m_last(m_last), .err_addr(err_addr), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    assert (got === want) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, want);
    end
  endtask

  function automatic logic [29:0] val(input int i, input int seed);
    return 30'(i + seed * 1000003);
  endfunction

  function automatic logic [3839:0] mk_beat(input int addr, input int seed);
    logic [3839:0] b;
    for (int j = 0; j < 128; j++) b[30*j +: 30] = val(addr * 128 + j, seed);
    return b;
  endfunction

  task automatic set_exp(input int seed);
    for (int i = 0; i < 4096; i++) exp_mem[i] = val(i, seed);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input int addr, input int seed, input int gap);
    int n = 0;
    in_valid = 1'b1;
    in_addr  = 9'(addr);
    in_data  = mk_beat(addr, seed);
    while (!in_ready && n < 10000) begin
      tick();
      n++;
    end
    if (n >= 10000) chk("send_ready_timeout", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    repeat (gap) tick();
  endtask

  // Called right after the completing beat's edge: m_valid must rise exactly one edge later.
  task automatic check_first(input string tag);
    chk({tag, "_valid_at_T"}, 64'(m_valid), 64'd0);
    chk({tag, "_in_ready_at_T"}, 64'(in_ready), 64'd0);
    tick();
    chk({tag, "_first_out"}, {51'd0, m_valid, m_index}, {51'd0, 1'b1, 12'd0});
  endtask

  task automatic drain(input string tag, input int mode, input int abort_idx);
    int nx = 0, cyc = 0, bad_data = 0, bad_idx = 0, bad_last = 0, bad_rdy = 0, bad_hold = 0;
    logic pv = 1'b0, pr = 1'b0;
    logic [29:0] pd = '0;
    logic [11:0] pi = '0;
    logic [3:0]  pat = 4'b1001;
    bit aborted = 0;
    while (nx < 4096 && cyc < 20000) begin
      if (abort_idx >= 0 && m_valid && m_index == 12'(abort_idx)) begin
        aborted = 1;
        break;
      end
      m_ready = (mode == 1) ? pat[cyc % 4] : 1'b1;
      if (pv && !pr && (m_valid !== 1'b1 || m_data !== pd || m_index !== pi)) bad_hold++;
      if (in_ready !== 1'b0) bad_rdy++;
      if (m_valid && m_ready) begin
        if (m_index !== 12'(nx)) bad_idx++;
        if (m_data !== exp_mem[nx]) bad_data++;
        if (m_last !== (nx == 4095)) bad_last++;
        nx++;
      end
      pv = m_valid; pr = m_ready; pd = m_data; pi = m_index;
      tick();
      cyc++;
    end
    m_ready = 1'b0;
    chk({tag, "_data"}, 64'(bad_data), 64'd0);
    chk({tag, "_index"}, 64'(bad_idx), 64'd0);
    chk({tag, "_in_ready_low"}, 64'(bad_rdy), 64'd0);
    if (abort_idx >= 0) begin
      chk({tag, "_abort_reached"}, {32'(aborted), 32'(nx)}, {32'd1, 32'(abort_idx)});
    end else begin
      chk({tag, "_count"}, 64'(nx), 64'd4096);
      chk({tag, "_last"}, 64'(bad_last), 64'd0);
      chk({tag, "_hold"}, 64'(bad_hold), 64'd0);
      chk({tag, "_end_state"}, {62'd0, m_valid, in_ready}, {62'd0, 1'b0, 1'b1});
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_addr = '0; in_data = '0; m_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {in_ready, m_valid, m_last, err_addr, busy}, {1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    chk("reset_data_index", {m_data, m_index}, 64'd0);
    rst_n = 1'b1;
    tick();

    // 1: in-order fill, full-rate drain
    set_exp(0);
    for (int a = 0; a < 31; a++) send_beat(a, 0, 0);
    chk("t1_busy_partial", 64'(busy), 64'd1);
    send_beat(31, 0, 0);
    check_first("t1");
    drain("t1", 0, -1);
    chk("t1_err", 64'(err_addr), 64'd0);
    chk("t1_busy_idle", 64'(busy), 64'd0);

    // 2: reverse order with gaps; beat 0 completes the fill
    set_exp(1);
    for (int a = 31; a > 0; a--) send_beat(a, 1, 3);
    in_valid = 1'b1; in_addr = 9'd0; in_data = mk_beat(0, 1);
    tick();
    in_valid = 1'b0;
    check_first("t2");
    drain("t2", 0, -1);

    // 3: backpressure pattern 1,0,0,1
    set_exp(2);
    for (int a = 0; a < 32; a++) send_beat(a, 2, 0);
    tick();
    drain("t3", 1, -1);

    // 4: bad address and duplicate beat 5
    set_exp(3);
    for (int i = 640; i < 768; i++) exp_mem[i] = val(i, 4);
    for (int a = 0; a < 11; a++) send_beat(a, 3, 0);
    chk("t4_err_before", 64'(err_addr), 64'd0);
    send_beat(40, 9, 0);
    chk("t4_err_bad_addr", 64'(err_addr), 64'd1);
    for (int a = 11; a < 31; a++) send_beat(a, 3, 0);
    chk("t4_still_collect", 64'(in_ready), 64'd1);
    send_beat(5, 4, 0);
    chk("t4_dup_not_done", 64'(in_ready), 64'd1);
    send_beat(31, 3, 0);
    check_first("t4");
    drain("t4", 0, -1);
    chk("t4_err_sticky", 64'(err_addr), 64'd1);

    // 5: reset mid-drain, then a fresh polynomial
    set_exp(5);
    for (int a = 0; a < 32; a++) send_beat(a, 5, 0);
    tick();
    drain("t5a", 0, 1000);
    rst_n = 1'b0;
    #1;
    chk("t5_reset_async", {m_valid, in_ready, busy, err_addr}, {1'b0, 1'b1, 1'b0, 1'b0});
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    chk("t5_no_glitch", {m_valid, in_ready}, {1'b0, 1'b1});
    for (int a = 0; a < 31; a++) send_beat(a, 5, 0);
    send_beat(31, 5, 0);
    check_first("t5b");
    drain("t5b", 0, -1);

    // 6: next polynomial offered throughout the drain
    set_exp(6);
    for (int a = 0; a < 31; a++) send_beat(a, 6, 0);
    send_beat(31, 6, 0);
    check_first("t6a");
    in_valid = 1'b1; in_addr = 9'd0; in_data = mk_beat(0, 7);
    drain("t6a", 0, -1);
    chk("t6_not_yet_accepted", 64'(busy), 64'd0);
    tick();
    chk("t6_accepted_next", 64'(busy), 64'd1);
    in_valid = 1'b0;
    set_exp(7);
    for (int a = 1; a < 31; a++) send_beat(a, 7, 0);
    send_beat(31, 7, 0);
    check_first("t6b");
    drain("t6b", 0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
